// File: rtl/aq_mmu_sysmap_pkg.sv
// Shared encodings for the sysmap CSR block.
// Field codes, FSM states, flag reset value and entry count.
package aq_mmu_sysmap_pkg;

  localparam int ENTRY_NUM = 8;
  localparam logic [4:0] FLG_RST = 5'b10011;

  typedef enum logic [1:0] {
    SYSMAP_FLD_ADDR = 2'd0,
    SYSMAP_FLD_FLG  = 2'd1,
    SYSMAP_FLD_LOCK = 2'd2,
    SYSMAP_FLD_RSVD = 2'd3
  } sysmap_fld_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } sysmap_st_e;

endpackage

// File: rtl/aq_mmu_sysmap_csr_entry.sv
// One sysmap entry: base, flags and sticky lock bit.
// Ports: clk/rst, addr_we/addr_in, flg_we/flg_in, lock_set -> base, flg, lock.
module aq_mmu_sysmap_csr_entry
  import aq_mmu_sysmap_pkg::*;
#(
  parameter int AW = 16,
  parameter int FW = 5,
  parameter logic [FW-1:0] FLG_INIT = FLG_RST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          addr_we,
  input  logic [AW-1:0] addr_in,
  input  logic          flg_we,
  input  logic [FW-1:0] flg_in,
  input  logic          lock_set,
  output logic [AW-1:0] base,
  output logic [FW-1:0] flg,
  output logic          lock
);

  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '1;
      flg  <= FLG_INIT;
      lock <= 1'b0;
    end else begin
      if (addr_we)  base <= addr_in;
      if (flg_we)   flg  <= flg_in;
      if (lock_set) lock <= 1'b1;
    end
  end

endmodule

// File: rtl/aq_mmu_sysmap_csr.sv
// Sysmap CSR programming block: 8 entries, staged writes committed when MMU idle.
// Ports: csr_sysmap_* request, sysmap_csr_* response, mmu busy/upd, flat entry vectors.
module aq_mmu_sysmap_csr
  import aq_mmu_sysmap_pkg::*;
#(
  parameter int PA_WIDTH   = 28,
  parameter int ADDR_WIDTH = PA_WIDTH - 12,
  parameter int FLG_WIDTH  = 5
) (
  input  logic                            forever_cpuclk,
  input  logic                            cpurst,
  input  logic                            csr_sysmap_vld,
  input  logic                            csr_sysmap_wen,
  input  logic [2:0]                      csr_sysmap_idx,
  input  logic [1:0]                      csr_sysmap_field,
  input  logic [31:0]                     csr_sysmap_wdata,
  output logic                            sysmap_csr_cmplt,
  output logic                            sysmap_csr_err,
  output logic [31:0]                     sysmap_csr_rdata,
  output logic                            sysmap_csr_busy,
  input  logic                            mmu_sysmap_busy,
  output logic [ENTRY_NUM*ADDR_WIDTH-1:0] sysmap_base_addr,
  output logic [ENTRY_NUM*FLG_WIDTH-1:0]  sysmap_flg,
  output logic                            sysmap_mmu_upd
);

  sysmap_st_e state;
  sysmap_fld_e fld;

  logic [ADDR_WIDTH-1:0] base_arr [ENTRY_NUM];
  logic [FLG_WIDTH-1:0]  flg_arr  [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]  lock_vec;

  logic [2:0]            sh_idx;
  logic                  sh_is_flg;
  logic [ADDR_WIDTH-1:0] sh_data;

  logic        req, rd_req, wr_bad, wr_lock, wr_stage;
  logic        commit;
  logic [31:0] rd_val;
  logic        wdata_unused;

  assign fld = sysmap_fld_e'(csr_sysmap_field);
  assign req = csr_sysmap_vld && (state == ST_IDLE);

  assign rd_req  = req && !csr_sysmap_wen;
  assign wr_bad  = req && csr_sysmap_wen &&
                   (lock_vec[csr_sysmap_idx] || fld == SYSMAP_FLD_RSVD);
  assign wr_lock = req && csr_sysmap_wen &&
                   !lock_vec[csr_sysmap_idx] && fld == SYSMAP_FLD_LOCK;
  assign wr_stage = req && csr_sysmap_wen &&
                    !lock_vec[csr_sysmap_idx] &&
                    (fld == SYSMAP_FLD_ADDR || fld == SYSMAP_FLD_FLG);

  // A lookup starting during COMMIT pushes the write back to WAIT so the
  // active entries never move under an in-flight translation.
  assign commit = (state == ST_COMMIT) && !mmu_sysmap_busy;

  assign sysmap_csr_busy = (state != ST_IDLE);
  assign wdata_unused = ^csr_sysmap_wdata[31:ADDR_WIDTH];

  always_comb begin
    rd_val = '0;
    case (fld)
      SYSMAP_FLD_ADDR: rd_val = 32'(base_arr[csr_sysmap_idx]);
      SYSMAP_FLD_FLG:  rd_val = 32'(flg_arr[csr_sysmap_idx]);
      SYSMAP_FLD_LOCK: rd_val = 32'(lock_vec[csr_sysmap_idx]);
      default:         rd_val = '0;
    endcase
  end

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    aq_mmu_sysmap_csr_entry #(
      .AW       (ADDR_WIDTH),
      .FW       (FLG_WIDTH),
      .FLG_INIT (FLG_RST)
    ) u_ent (
      .clk      (forever_cpuclk),
      .rst      (cpurst),
      .addr_we  (commit && !sh_is_flg && sh_idx == 3'(i)),
      .addr_in  (sh_data),
      .flg_we   (commit && sh_is_flg && sh_idx == 3'(i)),
      .flg_in   (sh_data[FLG_WIDTH-1:0]),
      .lock_set (wr_lock && csr_sysmap_idx == 3'(i)),
      .base     (base_arr[i]),
      .flg      (flg_arr[i]),
      .lock     (lock_vec[i])
    );
    assign sysmap_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = base_arr[i];
    assign sysmap_flg[i*FLG_WIDTH +: FLG_WIDTH] = flg_arr[i];
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state            <= ST_IDLE;
      sysmap_csr_cmplt <= 1'b0;
      sysmap_csr_err   <= 1'b0;
      sysmap_csr_rdata <= '0;
      sysmap_mmu_upd   <= 1'b0;
      sh_idx           <= '0;
      sh_is_flg        <= 1'b0;
      sh_data          <= '0;
    end else begin
      sysmap_csr_cmplt <= 1'b0;
      sysmap_csr_err   <= 1'b0;
      sysmap_mmu_upd   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            rd_req: begin
              state            <= ST_RESP;
              sysmap_csr_cmplt <= 1'b1;
              sysmap_csr_rdata <= rd_val;
            end
            wr_bad: begin
              state            <= ST_RESP;
              sysmap_csr_cmplt <= 1'b1;
              sysmap_csr_err   <= 1'b1;
            end
            wr_lock: begin
              state            <= ST_RESP;
              sysmap_csr_cmplt <= 1'b1;
            end
            wr_stage: begin
              state     <= ST_WAIT;
              sh_idx    <= csr_sysmap_idx;
              sh_is_flg <= (fld == SYSMAP_FLD_FLG);
              sh_data   <= csr_sysmap_wdata[ADDR_WIDTH-1:0];
            end
            default: ;
          endcase
        end
        ST_WAIT: begin
          if (!mmu_sysmap_busy) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (commit) begin
            state            <= ST_IDLE;
            sysmap_csr_cmplt <= 1'b1;
            sysmap_mmu_upd   <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_mmu_sysmap_csr.sv
// Self-checking bench for aq_mmu_sysmap_csr.
// Scenario tasks plus a response scoreboard on cmplt.
module tb_aq_mmu_sysmap_csr;

  logic        clk;
  logic        rst;
  logic        vld, wen;
  logic [2:0]  idx;
  logic [1:0]  fld;
  logic [31:0] wdata;
  logic        cmplt, err, busy, mbusy, upd;
  logic [31:0] rdata;
  logic [127:0] base;
  logic [39:0]  flg;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  aq_mmu_sysmap_csr dut (
    .forever_cpuclk   (clk),
    .cpurst           (rst),
    .csr_sysmap_vld   (vld),
    .csr_sysmap_wen   (wen),
    .csr_sysmap_idx   (idx),
    .csr_sysmap_field (fld),
    .csr_sysmap_wdata (wdata),
    .sysmap_csr_cmplt (cmplt),
    .sysmap_csr_err   (err),
    .sysmap_csr_rdata (rdata),
    .sysmap_csr_busy  (busy),
    .mmu_sysmap_busy  (mbusy),
    .sysmap_base_addr (base),
    .sysmap_flg       (flg),
    .sysmap_mmu_upd   (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(vld && busy)) else $error("protocol: vld while busy");

  // scoreboard: pop one expectation per completion
  always @(negedge clk) begin
    if (upd) upd_cnt++;
    if (cmplt) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected err=%0b rdata=%h", err, rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (err !== e.err || (e.chk && rdata !== e.rd)) begin
          errors++;
          $display("FAIL resp err=%0b rdata=%h want err=%0b rdata=%h",
                   err, rdata, e.err, e.rd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // called at a negedge; returns at the following negedge
  task automatic send(input logic w, input logic [2:0] i,
                      input logic [1:0] f, input logic [31:0] d,
                      input logic xe, input logic xc,
                      input logic [31:0] xr);
    exp_t e;
    e.err = xe; e.chk = xc; e.rd = xr;
    q.push_back(e);
    vld = 1'b1; wen = w; idx = i; fld = f; wdata = d;
    @(negedge clk);
    vld = 1'b0; wen = 1'b0; wdata = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b want 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (base[i*16 +: 16] !== 16'hFFFF || flg[i*5 +: 5] !== 5'b10011) begin
        errors++;
        $display("FAIL reset_entry%0d base=%h flg=%b want ffff/10011",
                 i, base[i*16 +: 16], flg[i*5 +: 5]);
      end
    end
    checks++;
    if ({busy, upd, cmplt, err} !== 4'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%0b upd=%0b cmplt=%0b rdata=%h want 0",
               busy, upd, cmplt, rdata);
    end
  endtask

  task automatic test_write_addr();
    send(1'b1, 3'd2, 2'd0, 32'hABCD_8000, 1'b0, 1'b0, 32'h0);
    checks++;
    if (busy !== 1'b1 || cmplt !== 1'b0) begin
      errors++;
      $display("FAIL wr_c1 busy=%0b cmplt=%0b want 1/0", busy, cmplt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || base[47:32] !== 16'hFFFF) begin
      errors++;
      $display("FAIL wr_c2 busy=%0b base=%h want 1/ffff", busy, base[47:32]);
    end
    @(negedge clk);
    checks++;
    if (base[47:32] !== 16'h8000 || upd !== 1'b1 ||
        cmplt !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_c3 base=%h upd=%0b cmplt=%0b busy=%0b want 8000/1/1/0",
               base[47:32], upd, cmplt, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_write_stall();
    int u0;
    u0 = upd_cnt;
    mbusy = 1'b1;
    send(1'b1, 3'd5, 2'd1, 32'h0000_000F, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (flg[29:25] !== 5'b10011 || upd !== 1'b0 || cmplt !== 1'b0) begin
        errors++;
        $display("FAIL stall_c%0d flg=%b upd=%0b want 10011/0", c, flg[29:25], upd);
      end
      @(negedge clk);
    end
    mbusy = 1'b0;
    @(negedge clk);
    checks++;
    if (flg[29:25] !== 5'b10011 || upd !== 1'b0) begin
      errors++;
      $display("FAIL stall_commit_cyc flg=%b upd=%0b want 10011/0", flg[29:25], upd);
    end
    @(negedge clk);
    checks++;
    if (flg[29:25] !== 5'b01111 || upd !== 1'b1 || cmplt !== 1'b1) begin
      errors++;
      $display("FAIL stall_done flg=%b upd=%0b cmplt=%0b want 01111/1/1",
               flg[29:25], upd, cmplt);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (upd_cnt - u0 != 1) begin
      errors++;
      $display("FAIL stall_upd_count got %0d want 1", upd_cnt - u0);
    end
  endtask

  task automatic test_lock();
    int u0;
    u0 = upd_cnt;
    send(1'b1, 3'd1, 2'd2, 32'h1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (cmplt !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL lock_resp cmplt=%0b err=%0b want 1/0", cmplt, err);
    end
    @(negedge clk);
    send(1'b1, 3'd1, 2'd0, 32'h1234, 1'b1, 1'b0, 32'h0);
    checks++;
    if (cmplt !== 1'b1 || err !== 1'b1 || base[31:16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL locked_wr cmplt=%0b err=%0b base=%h want 1/1/ffff",
               cmplt, err, base[31:16]);
    end
    wait_idle();
    send(1'b1, 3'd3, 2'd3, 32'h5, 1'b1, 1'b0, 32'h0);
    wait_idle();
    checks++;
    if (upd_cnt != u0 || base[31:16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL lock_no_upd upd_delta=%0d base=%h want 0/ffff",
               upd_cnt - u0, base[31:16]);
    end
  endtask

  task automatic test_read();
    send(1'b0, 3'd2, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_8000);
    checks++;
    if (cmplt !== 1'b1 || rdata !== 32'h0000_8000) begin
      errors++;
      $display("FAIL rd_addr cmplt=%0b rdata=%h want 1/00008000", cmplt, rdata);
    end
    wait_idle();
    send(1'b0, 3'd2, 2'd3, 32'h0, 1'b0, 1'b1, 32'h0);
    wait_idle();
    send(1'b0, 3'd5, 2'd1, 32'h0, 1'b0, 1'b1, 32'h0000_000F);
    wait_idle();
    send(1'b0, 3'd1, 2'd2, 32'h0, 1'b0, 1'b1, 32'h1);
    wait_idle();
    send(1'b0, 3'd7, 2'd1, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    mbusy = 1'b1;
    send(1'b1, 3'd0, 2'd0, 32'h0ABC, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    rst = 1'b0;
    mbusy = 1'b0;
    checks++;
    if (busy !== 1'b0 || base[15:0] !== 16'hFFFF || upd !== 1'b0 ||
        cmplt !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid busy=%0b base0=%h upd=%0b cmplt=%0b want 0/ffff/0/0",
               busy, base[15:0], upd, cmplt);
    end
    send(1'b0, 3'd0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_FFFF);
    checks++;
    if (cmplt !== 1'b1 || base[15:0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL rst_mid_req cmplt=%0b base0=%h want 1/ffff", cmplt, base[15:0]);
    end
    wait_idle();
    send(1'b0, 3'd1, 2'd2, 32'h0, 1'b0, 1'b1, 32'h0);
    wait_idle();
    send(1'b0, 3'd2, 2'd0, 32'h0, 1'b0, 1'b1, 32'h0000_FFFF);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; wen = 1'b0; idx = '0; fld = '0;
    wdata = '0; mbusy = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_addr();
    test_write_stall();
    test_lock();
    test_read();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
